// File: rtl/can_error_frame_gen.sv
// Purpose: CAN error-frame generator; drives the error flag, waits for a recessive bus, counts the delimiter, pulses done.
// Latency: triggers on the first SP rising edge at/after an error; TX/Error_Active change on that edge, visible next clock.
// Backpressure: none; progress is paced only by SP rising edges, so SP held high (or low) stalls the frame in place.
module can_error_frame_gen #(
    parameter int FLAG_LEN  = 6,
    parameter int DELIM_LEN = 8,
    parameter int MAX_DOM   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       SP,
    input  logic       RX,
    input  logic       EOF_Error,
    input  logic       Other_Error,
    output logic       TX,
    output logic       Error_Active,
    output logic       Error_Done,
    output logic [1:0] Error_Source,
    output logic       Dominant_Overrun
);

    typedef enum logic [2:0] {
        IDLE,
        FLAG,
        WAIT_REC,
        DELIM,
        DONE
    } state_t;

    localparam logic [3:0] FLAG_L  = 4'(FLAG_LEN);
    localparam logic [4:0] DELIM_L = 5'(DELIM_LEN);
    localparam logic [4:0] DOM_L   = 5'(MAX_DOM);

    state_t     state;
    state_t     state_nxt;
    logic       sp_d;
    logic       spe;
    logic       any_err;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic [3:0] dom_cnt;
    logic [3:0] dom_cnt_nxt;
    logic [4:0] cnt_inc;
    logic [4:0] dom_inc;
    logic       tx_q;
    logic       tx_nxt;
    logic [1:0] src_q;
    logic [1:0] src_nxt;
    logic       ovr_q;
    logic       ovr_nxt;
    logic       pend_eof;
    logic       pend_eof_nxt;
    logic       pend_oth;
    logic       pend_oth_nxt;

    assign spe     = SP & ~sp_d;
    assign any_err = EOF_Error | Other_Error;
    // One bit wider so the +1 comparisons cannot wrap at 15.
    assign cnt_inc = {1'b0, cnt} + 5'd1;
    assign dom_inc = {1'b0, dom_cnt} + 5'd1;

    // SP edge detector; resets high so an SP already high at reset release is not taken as an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sp_d <= 1'b1;
        end else begin
            sp_d <= SP;
        end
    end

    // State, counters, latched error info and registered bus outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            dom_cnt  <= 4'd0;
            tx_q     <= 1'b1;
            src_q    <= 2'b00;
            ovr_q    <= 1'b0;
            pend_eof <= 1'b0;
            pend_oth <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dom_cnt  <= dom_cnt_nxt;
            tx_q     <= tx_nxt;
            src_q    <= src_nxt;
            ovr_q    <= ovr_nxt;
            pend_eof <= pend_eof_nxt;
            pend_oth <= pend_oth_nxt;
        end
    end

    // Next-state and datapath; only error latching and the DONE exit act without a sample-point edge.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        dom_cnt_nxt  = dom_cnt;
        tx_nxt       = tx_q;
        src_nxt      = src_q;
        ovr_nxt      = ovr_q;
        pend_eof_nxt = pend_eof;
        pend_oth_nxt = pend_oth;

        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (spe && (pend_eof || pend_oth || any_err)) begin
                    // Source combines errors remembered since the last edge with any arriving now.
                    src_nxt      = {pend_eof | EOF_Error, pend_oth | Other_Error};
                    tx_nxt       = 1'b0;
                    cnt_nxt      = 4'd1;
                    ovr_nxt      = 1'b0;
                    pend_eof_nxt = 1'b0;
                    pend_oth_nxt = 1'b0;
                    state_nxt    = FLAG;
                end else if (any_err) begin
                    pend_eof_nxt = pend_eof | EOF_Error;
                    pend_oth_nxt = pend_oth | Other_Error;
                end
            end

            FLAG: begin
                if (spe) begin
                    if (cnt == FLAG_L) begin
                        tx_nxt      = 1'b1;
                        dom_cnt_nxt = 4'd0;
                        state_nxt   = WAIT_REC;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end

            WAIT_REC: begin
                if (spe) begin
                    if (RX) begin
                        // This recessive bit is the first delimiter bit.
                        cnt_nxt   = 4'd1;
                        state_nxt = DELIM;
                    end else begin
                        dom_cnt_nxt = (dom_cnt == 4'hF) ? 4'hF : dom_cnt + 4'd1;
                        if (dom_inc == DOM_L) begin
                            ovr_nxt = 1'b1;
                        end
                    end
                end
            end

            DELIM: begin
                if (spe) begin
                    if (RX) begin
                        if (cnt_inc == DELIM_L) begin
                            state_nxt = DONE;
                        end else begin
                            cnt_nxt = cnt_inc[3:0];
                        end
                    end else begin
                        // Dominant bit inside the delimiter: restart with a fresh flag.
                        tx_nxt    = 1'b0;
                        cnt_nxt   = 4'd1;
                        state_nxt = FLAG;
                    end
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign TX               = tx_q;
    assign Error_Active     = (state != IDLE);
    assign Error_Done       = (state == DONE);
    assign Error_Source     = src_q;
    assign Dominant_Overrun = ovr_q;

endmodule

// File: tb/tb_can_error_frame_gen.sv
// Purpose: randomized scoreboard bench for can_error_frame_gen against a bit-stream reference model.
// Latency: each bit slot pushes one expectation; the monitor checks it on the negedge after the SP rising edge acts.
// Backpressure: n/a; the bench owns SP pacing and holds SP high across a reset release to probe edge suppression.
module tb_can_error_frame_gen;

    localparam int FLAG_LEN  = 6;
    localparam int DELIM_LEN = 8;
    localparam int MAX_DOM   = 8;
    localparam int NS        = 96;

    logic       clock = 1'b0;
    logic       reset;
    logic       SP;
    logic       RX;
    logic       EOF_Error;
    logic       Other_Error;
    logic       TX;
    logic       Error_Active;
    logic       Error_Done;
    logic [1:0] Error_Source;
    logic       Dominant_Overrun;

    typedef struct packed {
        logic       tx;
        logic       act;
        logic       done;
        logic [1:0] src;
        logic       ovr;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    logic [1:0] cur_src = 2'b00;
    logic       cur_ovr = 1'b0;
    bit         rx_pat[NS];
    bit         m_tx[NS];
    bit         m_ovr[NS];
    int         done_slot;

    can_error_frame_gen #(
        .FLAG_LEN (FLAG_LEN),
        .DELIM_LEN(DELIM_LEN),
        .MAX_DOM  (MAX_DOM)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .SP              (SP),
        .RX              (RX),
        .EOF_Error       (EOF_Error),
        .Other_Error     (Other_Error),
        .TX              (TX),
        .Error_Active    (Error_Active),
        .Error_Done      (Error_Done),
        .Error_Source    (Error_Source),
        .Dominant_Overrun(Dominant_Overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e.tx   = 1'b1;
        e.act  = 1'b0;
        e.done = 1'b0;
        e.src  = cur_src;
        e.ovr  = cur_ovr;
        return e;
    endfunction

    // One bit slot of 4 clocks: SP high 2, low 2. e1/o1 coincide with the SP edge, e2/o2 fall in the low phase.
    task automatic slot(input bit rx, input bit e1, input bit o1, input bit e2, input bit o2, input exp_t e);
        @(posedge clock); #1;
        SP = 1'b1; RX = rx; EOF_Error = e1; Other_Error = o1;
        exp_q.push_back(e);
        @(posedge clock); #1;
        EOF_Error = 1'b0; Other_Error = 1'b0;
        @(posedge clock); #1;
        SP = 1'b0; EOF_Error = e2; Other_Error = o2;
        @(posedge clock); #1;
        EOF_Error = 1'b0; Other_Error = 1'b0;
    endtask

    // Bus bit stream for one frame, slot 0 = trigger edge: random bits under the flag, w1 dominant bits,
    // optionally a delimiter broken at bit intr followed by a second flag and w2 dominant bits, then recessive.
    task automatic build_pattern(input int w1, input int intr, input int w2);
        int p;
        for (int i = 0; i < NS; i++) rx_pat[i] = 1'b1;
        for (int i = 0; i <= FLAG_LEN; i++) rx_pat[i] = bit'($urandom_range(0, 1));
        p = FLAG_LEN + 1;
        for (int i = 0; i < w1; i++) begin rx_pat[p] = 1'b0; p++; end
        if (intr != 0) begin
            for (int k = 1; k < intr; k++) begin rx_pat[p] = 1'b1; p++; end
            rx_pat[p] = 1'b0; p++;
            for (int k = 0; k < FLAG_LEN; k++) begin rx_pat[p] = bit'($urandom_range(0, 1)); p++; end
            for (int i = 0; i < w2; i++) begin rx_pat[p] = 1'b0; p++; end
        end
    endtask

    // Reference: flag of FLAG_LEN low bits, then skip dominant bits (overrun once MAX_DOM seen), then need
    // DELIM_LEN consecutive recessive bits; a dominant bit inside that run starts a new flag on that bit.
    task automatic model();
        int s;
        int dom;
        int run;
        bit ovr;
        bit fin;
        s = 0; ovr = 1'b0; fin = 1'b0;
        for (int i = 0; i < NS; i++) begin m_tx[i] = 1'b1; m_ovr[i] = 1'b0; end
        while (!fin && s < NS - FLAG_LEN - 2) begin
            for (int k = 0; k < FLAG_LEN; k++) begin m_tx[s] = 1'b0; m_ovr[s] = ovr; s++; end
            m_tx[s] = 1'b1; m_ovr[s] = ovr; s++;
            dom = 0;
            while (s < NS - 1 && !rx_pat[s]) begin
                dom++;
                if (dom >= MAX_DOM) ovr = 1'b1;
                m_tx[s] = 1'b1; m_ovr[s] = ovr; s++;
            end
            run = 0;
            while (!fin && s < NS - 1 && rx_pat[s]) begin
                run++;
                m_tx[s] = 1'b1; m_ovr[s] = ovr;
                if (run == DELIM_LEN) fin = 1'b1;
                else s++;
            end
        end
        done_slot = s;
    endtask

    // mode 0: error pulsed in a preceding idle slot; 1: error on the trigger edge; 2: already pending.
    task automatic run_frame(input int mode, input bit eof, input bit oth, input int w1, input int intr,
                             input int w2, input bit noise, input int rst_at);
        exp_t e;
        bit   e1, o1, e2, o2;
        build_pattern(w1, intr, w2);
        model();
        if (mode == 0) slot(1'b1, 1'b0, 1'b0, eof, oth, idle_exp());
        for (int j = 0; j <= done_slot; j++) begin
            if (rst_at >= 0 && j > rst_at) break;
            e.tx   = m_tx[j];
            e.act  = 1'b1;
            e.done = (j == done_slot);
            e.src  = {eof, oth};
            e.ovr  = m_ovr[j];
            e1 = (mode == 1 && j == 0) ? eof : 1'b0;
            o1 = (mode == 1 && j == 0) ? oth : 1'b0;
            e2 = 1'b0;
            o2 = 1'b0;
            if (noise && j > 0 && j < done_slot) begin
                e1 = bit'($urandom_range(0, 1)); o1 = bit'($urandom_range(0, 1));
                e2 = bit'($urandom_range(0, 1)); o2 = bit'($urandom_range(0, 1));
            end
            slot(rx_pat[j], e1, o1, e2, o2, e);
        end
        if (rst_at >= 0) begin
            @(posedge clock); #1;
            reset = 1'b1;
            @(posedge clock);
            @(negedge clock);
            check("midreset_tx", int'(TX), 1);
            check("midreset_active", int'(Error_Active), 0);
            check("midreset_done", int'(Error_Done), 0);
            check("midreset_source", int'(Error_Source), 0);
            check("midreset_overrun", int'(Dominant_Overrun), 0);
            @(posedge clock); #1;
            reset = 1'b0;
            cur_src = 2'b00;
            cur_ovr = 1'b0;
        end else begin
            cur_src = {eof, oth};
            cur_ovr = m_ovr[done_slot];
        end
        slot(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, idle_exp());
    endtask

    // Monitor: arms on an SP rise seen outside reset, checks the popped expectation one negedge later;
    // on all other negedges Error_Done must stay low.
    initial begin : monitor
        bit   sp_prev;
        bit   armed;
        exp_t e;
        sp_prev = 1'b1;
        armed   = 1'b0;
        forever begin
            @(negedge clock);
            if (armed) begin
                armed = 1'b0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_edge: no expectation queued at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("tx", int'(TX), int'(e.tx));
                    check("active", int'(Error_Active), int'(e.act));
                    check("done", int'(Error_Done), int'(e.done));
                    check("source", int'(Error_Source), int'(e.src));
                    check("overrun", int'(Dominant_Overrun), int'(e.ovr));
                end
            end else begin
                check("stray_done", int'(Error_Done), 0);
            end
            if (SP && !sp_prev && !reset) armed = 1'b1;
            sp_prev = SP;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int mode, w1, intr, w2, rst_at;
        bit eof, oth, noise;

        reset = 1'b1; SP = 1'b0; RX = 1'b1; EOF_Error = 1'b0; Other_Error = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_tx", int'(TX), 1);
        check("reset_active", int'(Error_Active), 0);
        check("reset_done", int'(Error_Done), 0);
        check("reset_source", int'(Error_Source), 0);
        check("reset_overrun", int'(Dominant_Overrun), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        slot(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, idle_exp());

        run_frame(0, 1'b1, 1'b0, 0, 0, 0, 1'b0, -1);           // minimum frame, EOF source
        run_frame(0, 1'b0, 1'b1, 3, 0, 0, 1'b0, -1);           // superposition, no overrun
        run_frame(1, 1'b1, 1'b0, 8, 0, 0, 1'b0, -1);           // overrun exactly at MAX_DOM
        run_frame(0, 1'b0, 1'b1, 7, 0, 0, 1'b0, -1);           // one short of overrun
        run_frame(0, 1'b1, 1'b0, 0, 5, 0, 1'b0, -1);           // delimiter broken at bit 5
        run_frame(0, 1'b1, 1'b0, 0, DELIM_LEN, 9, 1'b0, -1);   // broken at last bit, overrun on second flag
        run_frame(0, 1'b1, 1'b0, 0, 0, 0, 1'b1, -1);           // errors during the frame are ignored
        run_frame(0, 1'b0, 1'b1, 0, 0, 0, 1'b0, FLAG_LEN + 3); // reset inside the delimiter
        run_frame(1, 1'b1, 1'b1, 0, 0, 0, 1'b0, -1);           // both errors on the same clock
        run_frame(0, 1'b1, 1'b1, 2, 0, 0, 1'b0, -1);

        // SP high through reset release: no edge, so a pending error must wait for a genuine rise.
        @(posedge clock); #1;
        SP = 1'b1; reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        EOF_Error = 1'b1;
        @(posedge clock); #1;
        EOF_Error = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("sphigh_active", int'(Error_Active), 0);
        check("sphigh_tx", int'(TX), 1);
        check("sphigh_source", int'(Error_Source), 0);
        @(posedge clock); #1;
        SP = 1'b0;
        cur_src = 2'b00;
        cur_ovr = 1'b0;
        run_frame(2, 1'b1, 1'b0, 0, 0, 0, 1'b0, -1);

        for (int n = 0; n < 30; n++) begin
            mode  = $urandom_range(0, 1);
            eof   = bit'($urandom_range(0, 1));
            oth   = bit'($urandom_range(0, 1));
            if (!eof && !oth) oth = 1'b1;
            w1    = $urandom_range(0, 11);
            intr  = ($urandom_range(0, 2) == 0) ? $urandom_range(2, DELIM_LEN) : 0;
            w2    = $urandom_range(0, 11);
            noise = bit'($urandom_range(0, 1));
            rst_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 12) : -1;
            run_frame(mode, eof, oth, w1, intr, w2, noise, rst_at);
        end

        repeat (4) @(posedge clock);
        @(negedge clock);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
